// File: rtl/uart_transmitter.sv
// UART transmit path: start bit, 1-8 data bits LSB first, 1 or 2 stop bits.
// A one-word holding buffer in front of the shifter lets the producer queue
// the next word while the current frame is still on the line, so consecutive
// frames follow each other with no idle gap.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for the holding buffer to fill
// START | start bit (0) for one bit period
// DATA  | data bits, LSB first, one bit period each
// STOP  | stop bit(s) (1), one or two bit periods
module uart_transmitter (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] clocksPerCycle,
  input  logic [3:0]  bitsPerFrame,
  input  logic        twoStopBits,
  input  logic        txValid,
  input  logic [7:0]  txData,
  output logic        txReady,
  output logic        tx,
  output logic        txBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  hold, hold_nxt;
  logic        hold_full, hold_full_nxt;
  logic [7:0]  shifter, shifter_nxt;
  logic [15:0] cyc_cnt, cyc_cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [15:0] cfg_cpc, cfg_cpc_nxt;
  logic [3:0]  cfg_bits, cfg_bits_nxt;
  logic        cfg_two, cfg_two_nxt;
  logic        tx_nxt;

  logic [15:0] eff_cpc;
  logic [3:0]  eff_bits;
  logic        period_end;
  logic        last_stop;
  logic        accept;
  logic        load;

  // Clamp the raw configuration into its legal range before it is latched.
  always_comb begin
    eff_cpc  = (clocksPerCycle == 16'd0) ? 16'd1 : clocksPerCycle;
    eff_bits = bitsPerFrame;
    if (bitsPerFrame == 4'd0) begin
      eff_bits = 4'd1;
    end else if (bitsPerFrame > 4'd8) begin
      eff_bits = 4'd8;
    end
  end

  // The cycle counter never exceeds cfg_cpc, so 16 bits cannot wrap even
  // at the 16'hFFFF setting.
  assign period_end = (cyc_cnt >= cfg_cpc);
  assign last_stop  = cfg_two ? (bit_cnt >= 4'd2) : 1'b1;
  assign accept     = txValid && !hold_full;

  assign txReady = !hold_full;
  assign txBusy  = (state != IDLE) || hold_full;

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    shifter_nxt   = shifter;
    cyc_cnt_nxt   = cyc_cnt;
    bit_cnt_nxt   = bit_cnt;
    cfg_cpc_nxt   = cfg_cpc;
    cfg_bits_nxt  = cfg_bits;
    cfg_two_nxt   = cfg_two;
    tx_nxt        = tx;
    load          = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt      = 1'b1;
        cyc_cnt_nxt = 16'd1;
        bit_cnt_nxt = 4'd1;
        if (hold_full) begin
          load = 1'b1;
        end
      end

      START: begin
        if (period_end) begin
          cyc_cnt_nxt = 16'd1;
          state_nxt   = DATA;
          tx_nxt      = shifter[0];
        end else begin
          cyc_cnt_nxt = cyc_cnt + 16'd1;
        end
      end

      DATA: begin
        if (period_end) begin
          cyc_cnt_nxt = 16'd1;
          if (bit_cnt >= cfg_bits) begin
            state_nxt   = STOP;
            tx_nxt      = 1'b1;
            bit_cnt_nxt = 4'd1;
          end else begin
            shifter_nxt = {1'b0, shifter[7:1]};
            tx_nxt      = shifter[1];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else begin
          cyc_cnt_nxt = cyc_cnt + 16'd1;
        end
      end

      STOP: begin
        if (period_end) begin
          cyc_cnt_nxt = 16'd1;
          if (last_stop) begin
            // A queued word goes straight into its start bit: no idle gap.
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_nxt   = IDLE;
              tx_nxt      = 1'b1;
              bit_cnt_nxt = 4'd1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else begin
          cyc_cnt_nxt = cyc_cnt + 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase

    // Frame start: move the held word into the shifter and freeze the
    // configuration for the whole frame.
    if (load) begin
      shifter_nxt   = hold;
      hold_full_nxt = 1'b0;
      tx_nxt        = 1'b0;
      state_nxt     = START;
      cyc_cnt_nxt   = 16'd1;
      bit_cnt_nxt   = 4'd1;
      cfg_cpc_nxt   = eff_cpc;
      cfg_bits_nxt  = eff_bits;
      cfg_two_nxt   = twoStopBits;
    end

    // accept needs hold_full=0 and load needs hold_full=1, so they never
    // collide on the same edge.
    if (accept) begin
      hold_nxt      = txData;
      hold_full_nxt = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset; reset aborts any
  // frame in progress and drops a pending word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= 8'd0;
      hold_full <= 1'b0;
      shifter   <= 8'd0;
      cyc_cnt   <= 16'd1;
      bit_cnt   <= 4'd1;
      cfg_cpc   <= 16'd1;
      cfg_bits  <= 4'd1;
      cfg_two   <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      shifter   <= shifter_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      cfg_cpc   <= cfg_cpc_nxt;
      cfg_bits  <= cfg_bits_nxt;
      cfg_two   <= cfg_two_nxt;
      tx        <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: directed frame table, back-to-back and
// reset corner sequences, randomized traffic against a frame-level line
// model, and a loopback through a behavioural receiver.
module tb_uart_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpc;
  logic [3:0]  bits;
  logic        two;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_line;
  logic        tx_busy;

  always #5 clk = ~clk;

  uart_transmitter dut (
    .clk            (clk),
    .reset          (reset),
    .clocksPerCycle (cpc),
    .bitsPerFrame   (bits),
    .twoStopBits    (two),
    .txValid        (tx_valid),
    .txData         (tx_data),
    .txReady        (tx_ready),
    .tx             (tx_line),
    .txBusy         (tx_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line model ----------------
  // A frame is expanded into its per-clock line values when it starts;
  // the line follows that list, then idles high.
  logic       line_q[$];
  logic [7:0] sent_q[$];
  logic       m_hold_full = 1'b0;
  logic       m_in_frame  = 1'b0;
  logic       m_tx        = 1'b1;
  logic [7:0] m_hold      = 8'd0;
  logic       m_hf;
  int         m_c, m_nb, m_ns;

  always @(posedge clk) begin : model
    if (reset) begin
      line_q.delete();
      m_hold_full = 1'b0;
      m_in_frame  = 1'b0;
      m_tx        = 1'b1;
    end else begin
      m_hf = m_hold_full;
      if (line_q.size() == 0 && m_hf) begin
        m_c  = (cpc == 16'd0) ? 1 : int'(cpc);
        m_nb = (bits == 4'd0) ? 1 : ((bits > 4'd8) ? 8 : int'(bits));
        m_ns = two ? 2 : 1;
        for (int k = 0; k < m_c; k++) line_q.push_back(1'b0);
        for (int b = 0; b < m_nb; b++)
          for (int k = 0; k < m_c; k++) line_q.push_back(m_hold[b]);
        for (int k = 0; k < m_ns * m_c; k++) line_q.push_back(1'b1);
        m_hold_full = 1'b0;
      end
      if (line_q.size() > 0) begin
        m_tx       = line_q.pop_front();
        m_in_frame = 1'b1;
      end else begin
        m_tx       = 1'b1;
        m_in_frame = 1'b0;
      end
      if (tx_valid && !m_hf) begin
        m_hold_full = 1'b1;
        m_hold      = tx_data;
        sent_q.push_back(tx_data);
      end
    end
  end

  logic chk_en = 1'b0;

  // Every cycle, compare all outputs to the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx",    32'(tx_line),  32'(m_tx));
      check("model_ready", 32'(tx_ready), 32'(!m_hold_full));
      check("model_busy",  32'(tx_busy),  32'(m_in_frame || m_hold_full));
    end
  end

  // ---------------- loopback receiver (16 clocks per bit, 8N1) ----------------
  logic       rx_en = 1'b0;
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rcvd = 0;
  logic [7:0] rx_byte = 8'd0;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (rx_en) begin
      if (!rx_active) begin
        if (tx_line == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % 16 == 8) begin
          if (rx_cnt / 16 >= 1 && rx_cnt / 16 <= 8) begin
            rx_byte[rx_cnt / 16 - 1] = tx_line;
          end else if (rx_cnt / 16 == 9) begin
            check("loop_stop_bit", 32'(tx_line), 32'd1);
            rx_exp = (sent_q.size() > 0) ? sent_q.pop_front() : ~rx_byte;
            check("loop_word", 32'(rx_byte), 32'(rx_exp));
            rcvd++;
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  localparam int LIMIT = 4000;

  task automatic send_word(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (m_hold_full && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", 32'(n >= LIMIT), 32'd0);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((m_in_frame || m_hold_full) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n >= LIMIT), 32'd0);
  endtask

  typedef struct {
    logic [15:0] cpc;
    logic [3:0]  bits;
    logic        two;
    logic [7:0]  data;
    int          eff;
    int          chg_at;
    string       name;
    string       pat;
  } vec_t;

  vec_t vecs[5];
  string b2b_pat;
  int    lows;
  int    n_wait;
  int    plen;

  initial begin
    vecs[0] = '{cpc:16'd4, bits:4'd8,  two:1'b0, data:8'hA5, eff:4, chg_at:-1, name:"single_a5",       pat:"0101001011"};
    vecs[1] = '{cpc:16'd0, bits:4'd0,  two:1'b0, data:8'h03, eff:1, chg_at:-1, name:"limits_min",      pat:"011"};
    vecs[2] = '{cpc:16'd3, bits:4'd5,  two:1'b1, data:8'h1F, eff:3, chg_at:4,  name:"two_stop_latch",  pat:"01111111"};
    vecs[3] = '{cpc:16'd2, bits:4'd12, two:1'b0, data:8'h96, eff:2, chg_at:-1, name:"bits_over_8",     pat:"0011010011"};
    vecs[4] = '{cpc:16'd1, bits:4'd3,  two:1'b1, data:8'h05, eff:1, chg_at:-1, name:"three_bits_2stop",pat:"010111"};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    cpc      = 16'd4;
    bits     = 4'd8;
    two      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_tx",    32'(tx_line),  32'd1);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_busy",  32'(tx_busy),  32'd0);
    reset = 1'b0;

    // Directed single frames from the table.
    foreach (vecs[v]) begin
      wait_idle();
      cpc  = vecs[v].cpc;
      bits = vecs[v].bits;
      two  = vecs[v].two;
      send_word(vecs[v].data);
      plen = vecs[v].pat.len() * vecs[v].eff;
      for (int i = 0; i < plen; i++) begin
        @(posedge clk);
        @(negedge clk);
        check({vecs[v].name, "_bit"}, 32'(tx_line),
              32'(vecs[v].pat[i / vecs[v].eff] == 8'h31));
        if (i == vecs[v].chg_at) cpc = 16'd10;
      end
      @(posedge clk);
      @(negedge clk);
      check({vecs[v].name, "_end_tx"},   32'(tx_line), 32'd1);
      check({vecs[v].name, "_end_busy"}, 32'(tx_busy), 32'd0);
    end

    // Back-to-back frames: second word queued during the first frame.
    wait_idle();
    cpc  = 16'd4;
    bits = 4'd8;
    two  = 1'b0;
    b2b_pat = {"0101010101", "0111100001"};
    send_word(8'h55);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h0F;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) tx_valid = 1'b0;
      @(negedge clk);
      check("b2b_tx",    32'(tx_line),  32'(b2b_pat[(k - 1) / 4] == 8'h31));
      check("b2b_ready", 32'(tx_ready), 32'(k == 1 || k >= 41));
      check("b2b_busy",  32'(tx_busy),  32'd1);
    end

    // Reset in the middle of a frame with a word waiting in the buffer.
    wait_idle();
    send_word(8'hC3);
    send_word(8'h3C);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_tx",    32'(tx_line),  32'd1);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_busy",  32'(tx_busy),  32'd0);
    reset = 1'b0;
    lows  = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx_line == 1'b0) lows++;
    end
    check("rst_no_stale_word", 32'(lows), 32'd0);

    // Randomized traffic, configuration churn and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      reset    = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 40) == 0) begin
        cpc  = 16'($urandom_range(0, 5));
        bits = 4'($urandom_range(0, 15));
        two  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    reset    = 1'b0;
    tx_valid = 1'b0;

    // Loopback through the behavioural receiver.
    wait_idle();
    cpc  = 16'd16;
    bits = 4'd8;
    two  = 1'b0;
    sent_q.delete();
    rcvd  = 0;
    rx_en = 1'b1;
    for (int w = 0; w < 256; w++) begin
      send_word(8'($urandom));
    end
    n_wait = 0;
    while (rcvd < 256 && n_wait < 5000) begin
      @(negedge clk);
      n_wait++;
    end
    check("loop_count", 32'(rcvd), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
